game_state_ctrl: RTL and testbench

//  Parametrised game-state controller and display overlay for the LED-matrix Snake game.

---
 rtl/game_state_ctrl.sv | 103 ++++++++++
 tb/tb_game_state_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game-state controller and LED-matrix overlay for Snake: tracks PLAY/PAUSE/OVER/WIN
// and drives registered red/green planes, blinking the apple or end banner when not playing.
module game_state_ctrl #(
  parameter int ROWS         = 16,
  parameter int COLS         = 16,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ROWS-1:0][COLS-1:0]  lights,
  input  logic [ROWS-1:0][COLS-1:0]  apple,
  input  logic [ROWS-1:0][COLS-1:0]  banner,
  input  logic                       collision,
  input  logic                       pause_req,
  input  logic                       restart,
  output logic [ROWS-1:0][COLS-1:0]  red_out,
  output logic [ROWS-1:0][COLS-1:0]  green_out,
  output logic [1:0]                 state_out,
  output logic                       game_active
);

  localparam int CW = $clog2(BLINK_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    PAUSE = 2'd1,
    OVER  = 2'd2,
    WIN   = 2'd3
  } state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              blink_cnt, blink_cnt_nxt;
  logic                       phase, phase_nxt;
  logic [ROWS-1:0][COLS-1:0]  red_nxt, green_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PLAY;
      blink_cnt <= '0;
      phase     <= 1'b1;
      red_out   <= '0;
      green_out <= '0;
    end else begin
      state     <= state_nxt;
      blink_cnt <= blink_cnt_nxt;
      phase     <= phase_nxt;
      red_out   <= red_nxt;
      green_out <= green_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    blink_cnt_nxt = blink_cnt;
    phase_nxt     = phase;
    red_nxt       = '0;
    green_nxt     = '0;

    if (restart) begin
      state_nxt = PLAY;
    end else begin
      case (state)
        PLAY: begin
          // Loss is checked before win so a simultaneous full board and collision ends in OVER.
          if (lights == '0 || collision) state_nxt = OVER;
          else if (lights == '1)         state_nxt = WIN;
          else if (pause_req)            state_nxt = PAUSE;
        end
        PAUSE:   if (pause_req) state_nxt = PLAY;
        default: state_nxt = state;
      endcase
    end

    // Every new state starts with a full visible half-period.
    if (state == PLAY || state_nxt != state) begin
      blink_cnt_nxt = '0;
      phase_nxt     = 1'b1;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt_nxt = '0;
      phase_nxt     = ~phase;
    end else begin
      blink_cnt_nxt = blink_cnt + CW'(1);
    end

    case (state)
      PLAY: begin
        red_nxt   = apple;
        green_nxt = lights;
      end
      PAUSE: begin
        red_nxt   = phase ? apple : '0;
        green_nxt = lights;
      end
      OVER:    red_nxt   = phase ? banner : '0;
      default: green_nxt = phase ? banner : '0;
    endcase
  end

  assign state_out   = state;
  assign game_active = (state == PLAY);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl at ROWS=8, COLS=32, BLINK_CYCLES=4:
// stimulus pushes hand-computed post-edge expectations, a monitor pops and compares.
module tb_game_state_ctrl;
  localparam int R = 8;
  localparam int C = 32;
  localparam int B = 4;

  typedef logic [R-1:0][C-1:0] plane_t;
  typedef struct packed {
    logic [1:0] st;
    plane_t     r;
    plane_t     g;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  plane_t     lights, apple, banner;
  logic       collision = 1'b0, pause_req = 1'b0, restart = 1'b0;
  plane_t     red_out, green_out;
  logic [1:0] state_out;
  logic       game_active;

  int total = 0;
  int bad   = 0;
  int nstep = 0;
  exp_t q[$];

  plane_t Z, A, L1, LF, BN;

  game_state_ctrl #(.ROWS(R), .COLS(C), .BLINK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .lights(lights), .apple(apple), .banner(banner),
    .collision(collision), .pause_req(pause_req), .restart(restart),
    .red_out(red_out), .green_out(green_out), .state_out(state_out),
    .game_active(game_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [R*C-1:0] act, input logic [R*C-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d act=%h exp=%h", nm, nstep, act, exp);
    end
  endtask

  // Drive one cycle of inputs and record what the outputs must be after the next edge.
  task automatic cyc(input logic c, input logic p, input logic r, input plane_t lt,
                     input logic [1:0] es, input plane_t er, input plane_t eg);
    exp_t e;
    @(negedge clk);
    collision = c;
    pause_req = p;
    restart   = r;
    lights    = lt;
    e.st = es;
    e.r  = er;
    e.g  = eg;
    q.push_back(e);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_state"}, (R*C)'(state_out), (R*C)'(0));
    chk({nm, "_active"}, (R*C)'(game_active), (R*C)'(1));
    chk({nm, "_red"}, red_out, Z);
    chk({nm, "_green"}, green_out, Z);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      nstep++;
      chk("state", (R*C)'(state_out), (R*C)'(e.st));
      chk("active", (R*C)'(game_active), (R*C)'(e.st == 2'd0));
      chk("red", red_out, e.r);
      chk("green", green_out, e.g);
    end
  end

  initial begin
    Z  = '0;
    A  = '0; A[5][5] = 1'b1;
    L1 = '0; L1[0][0] = 1'b1;
    LF = '1;
    for (int i = 0; i < R; i++) BN[i] = (i % 2 == 0) ? 32'hA5A5_0F0F : 32'h3C3C_F00F;
    lights = L1;
    apple  = A;
    banner = BN;

    #2 reset = 1'b0;
    #1 chk_reset("rst_init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // live board
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    // collision -> OVER, banner blinks 4 on / 4 off; pause_req ignored in OVER
    cyc(1, 0, 0, L1, 2'd2, A, L1);
    cyc(0, 0, 0, L1, 2'd2, BN, Z);
    cyc(0, 0, 0, L1, 2'd2, BN, Z);
    cyc(0, 0, 0, L1, 2'd2, BN, Z);
    cyc(0, 0, 0, L1, 2'd2, BN, Z);
    cyc(0, 0, 0, L1, 2'd2, Z, Z);
    cyc(0, 1, 0, L1, 2'd2, Z, Z);
    cyc(0, 0, 0, L1, 2'd2, Z, Z);
    cyc(0, 0, 0, L1, 2'd2, Z, Z);
    cyc(0, 0, 0, L1, 2'd2, BN, Z);
    // restart from OVER, then restart+pause_req in PLAY stays PLAY
    cyc(0, 0, 1, L1, 2'd0, BN, Z);
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    cyc(0, 1, 1, L1, 2'd0, A, L1);
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    // full board -> WIN, green banner blinks
    cyc(0, 0, 0, LF, 2'd3, A, LF);
    cyc(0, 0, 0, LF, 2'd3, Z, BN);
    cyc(0, 0, 0, LF, 2'd3, Z, BN);
    cyc(0, 0, 0, LF, 2'd3, Z, BN);
    cyc(0, 0, 0, LF, 2'd3, Z, BN);
    cyc(0, 0, 0, LF, 2'd3, Z, Z);
    cyc(0, 0, 1, L1, 2'd0, Z, Z);
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    // full board plus collision -> OVER
    cyc(1, 0, 0, LF, 2'd2, A, LF);
    cyc(0, 0, 0, LF, 2'd2, BN, Z);
    cyc(0, 0, 1, L1, 2'd0, BN, Z);
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    // empty board -> OVER
    cyc(0, 0, 0, Z, 2'd2, A, Z);
    cyc(0, 0, 1, L1, 2'd0, BN, Z);
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    // pause: apple blinks, collision ignored, second pause_req resumes
    cyc(0, 1, 0, L1, 2'd1, A, L1);
    cyc(1, 0, 0, L1, 2'd1, A, L1);
    cyc(0, 0, 0, L1, 2'd1, A, L1);
    cyc(0, 0, 0, L1, 2'd1, A, L1);
    cyc(0, 0, 0, L1, 2'd1, A, L1);
    cyc(0, 0, 0, L1, 2'd1, Z, L1);
    cyc(0, 1, 0, L1, 2'd0, Z, L1);
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    // async reset mid-blink in OVER
    cyc(1, 0, 0, L1, 2'd2, A, L1);
    cyc(0, 0, 0, L1, 2'd2, BN, Z);
    cyc(0, 0, 0, L1, 2'd2, BN, Z);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    cyc(0, 0, 0, L1, 2'd0, A, L1);
    @(negedge clk);
    collision = 1'b0;
    pause_req = 1'b0;
    restart   = 1'b0;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
